// File: rtl/duck_sprite_blitter.sv
// Blits a 4-bit indexed duck sprite from ROM into the framebuffer. Transparent texels are
// skipped and texels off the right or bottom edge are clipped. Optional macro BLIT_FLIP_X_EN.
//
// state   | meaning
// S_IDLE  | waiting for start; pos/flip latched on accept
// S_RUN   | one ROM address issued per cycle, raster order
// S_DRAIN | last texel's ROM data arrives; final write
// S_DONE  | done pulse, busy still high
module duck_sprite_blitter #(
   parameter int         SPR_W           = 64,
   parameter int         SPR_H           = 64,
   parameter int         FB_W            = 320,
   parameter int         FB_H            = 240,
   parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
   input  logic        i_vga_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [9:0]  i_pos_x,
   input  logic [9:0]  i_pos_y,
`ifdef BLIT_FLIP_X_EN
   input  logic        i_flip_x,
`endif
   output logic        o_busy,
   output logic        o_done,
   output logic [11:0] o_rom_address,
   input  logic [3:0]  i_rom_q,
   output logic        o_fb_we,
   output logic [16:0] o_fb_addr,
   output logic [3:0]  o_fb_data
);

   localparam int SXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int SYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [SXW-1:0] SX_LAST = SXW'(SPR_W - 1);
   localparam logic [SYW-1:0] SY_LAST = SYW'(SPR_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [9:0]       r_pos_x;
   logic [9:0]       r_pos_y;
   logic [SXW-1:0]   r_sx;
   logic [SYW-1:0]   r_sy;
   logic             r_p_valid;
   logic             r_p_inb;
   logic [16:0]      r_fb_addr;
   logic             w_last;
   logic [10:0]      w_scr_x;
   logic [10:0]      w_scr_y;
   logic             w_in_bounds;
   logic [16:0]      w_fb_addr;
   logic [SXW-1:0]   w_rom_col;

   assign w_last      = (r_sx == SX_LAST) && (r_sy == SY_LAST);
   // 11-bit sums so a far-right position clips instead of wrapping back on screen
   assign w_scr_x     = {1'b0, r_pos_x} + 11'(r_sx);
   assign w_scr_y     = {1'b0, r_pos_y} + 11'(r_sy);
   assign w_in_bounds = (w_scr_x < 11'(FB_W)) && (w_scr_y < 11'(FB_H));
   assign w_fb_addr   = 17'(w_scr_y) * 17'(FB_W) + 17'(w_scr_x);

`ifdef BLIT_FLIP_X_EN
   logic r_flip;
   assign w_rom_col = r_flip ? (SX_LAST - r_sx) : r_sx;
`else
   assign w_rom_col = r_sx;
`endif

   assign o_rom_address = 12'(r_sy) * 12'(SPR_W) + 12'(w_rom_col);

   always_ff @(posedge i_vga_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_RUN;
         S_RUN:   if (w_last)  w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != S_IDLE);
      o_done = (r_state == S_DONE);
   end

   always_ff @(posedge i_vga_clk) begin
      if (i_reset) begin
         r_pos_x   <= '0;
         r_pos_y   <= '0;
         r_sx      <= '0;
         r_sy      <= '0;
         r_p_valid <= 1'b0;
         r_p_inb   <= 1'b0;
         r_fb_addr <= '0;
`ifdef BLIT_FLIP_X_EN
         r_flip    <= 1'b0;
`endif
      end else begin
         r_p_valid <= (r_state == S_RUN);
         if (r_state == S_IDLE && i_start) begin
            r_pos_x <= i_pos_x;
            r_pos_y <= i_pos_y;
            r_sx    <= '0;
            r_sy    <= '0;
`ifdef BLIT_FLIP_X_EN
            r_flip  <= i_flip_x;
`endif
         end
         if (r_state == S_RUN) begin
            r_p_inb   <= w_in_bounds;
            r_fb_addr <= w_fb_addr;
            if (r_sx == SX_LAST) begin
               r_sx <= '0;
               r_sy <= (r_sy == SY_LAST) ? '0 : r_sy + 1'b1;
            end else begin
               r_sx <= r_sx + 1'b1;
            end
         end
      end
   end

   // ROM data for the texel issued last cycle arrives now; write decision is made against it
   assign o_fb_we   = r_p_valid && r_p_inb && (i_rom_q != TRANSPARENT_IDX);
   assign o_fb_data = r_p_valid ? i_rom_q : 4'h0;
   assign o_fb_addr = r_fb_addr;

endmodule

// File: tb/tb_duck_sprite_blitter.sv
// Self-checking bench for duck_sprite_blitter: a synchronous sprite ROM model feeds the DUT and a
// texel-loop reference model predicts every framebuffer write (cycle, address, data).
module tb_duck_sprite_blitter;

   typedef struct {int cyc; int addr; int data;} wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
`ifdef BLIT_FLIP_X_EN
   logic        flip_x;
`endif
   logic        busy;
   logic        done;
   logic [11:0] rom_address;
   logic [3:0]  rom_q;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [3:0]  fb_data;
   logic [3:0]  rom_mem [4096];

   int checks = 0;
   int errors = 0;
   int obs_writes, exp_writes, obs_done_c, done_cnt, busy_cnt, busy_end;
   int first_addr, first_cyc, last_addr, last_cyc;
   bit hit_addr0;

   duck_sprite_blitter dut (
      .i_vga_clk    (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_pos_x      (pos_x),
      .i_pos_y      (pos_y),
`ifdef BLIT_FLIP_X_EN
      .i_flip_x     (flip_x),
`endif
      .o_busy       (busy),
      .o_done       (done),
      .o_rom_address(rom_address),
      .i_rom_q      (rom_q),
      .o_fb_we      (fb_we),
      .o_fb_addr    (fb_addr),
      .o_fb_data    (fb_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom_mem[rom_address];

   task automatic fill_rom(input logic [3:0] v);
      for (int i = 0; i < 4096; i++) rom_mem[i] = v;
   endtask

   // Runs one blit from IDLE; predicts writes from the sprite rules and checks each one as it appears.
   task automatic run_blit(input string name, input logic [9:0] px, input logic [9:0] py,
                           input logic fx, input bit hold_start, input int pulse_c, input int abort_c);
      wr_t exp_q[$];
      wr_t e;
      int  col, scr_x, scr_y, v, k, c;
      bit  quiet;
      exp_q = {};
      for (int y = 0; y < 64; y++) begin
         for (int x = 0; x < 64; x++) begin
            col   = fx ? 63 - x : x;
            scr_x = int'(px) + x;
            scr_y = int'(py) + y;
            v     = int'(rom_mem[y * 64 + col]);
            k     = y * 64 + x;
            if (v != 0 && scr_x < 320 && scr_y < 240 && (abort_c < 0 || k + 2 <= abort_c))
               exp_q.push_back('{k + 2, scr_y * 320 + scr_x, v});
         end
      end
      exp_writes = exp_q.size();
      obs_writes = 0; obs_done_c = -1; done_cnt = 0; busy_cnt = 0; busy_end = -1;
      first_addr = -1; first_cyc = -1; last_addr = -1; last_cyc = -1; hit_addr0 = 0;
      pos_x = px; pos_y = py;
`ifdef BLIT_FLIP_X_EN
      flip_x = fx;
`endif
      start = 1'b1;
      @(posedge clk);
      for (c = 1; c <= 4099; c++) begin
         #1;
         if (c == 1) begin
            if (!hold_start) start = 1'b0;
            pos_x = 10'($urandom);
            pos_y = 10'($urandom);
         end
         if (c == pulse_c) start = 1'b1;
         if (c == pulse_c + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; obs_done_c = c; end
         if (c == 4099) busy_end = int'(busy);
         if (fb_we) begin
            obs_writes++;
            if (first_cyc < 0) begin first_cyc = c; first_addr = int'(fb_addr); end
            last_cyc = c; last_addr = int'(fb_addr);
            if (fb_addr == 17'd0) hit_addr0 = 1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_write: got cyc=%0d addr=%0d data=%0h, required no write", name, c, fb_addr, fb_data);
            end else begin
               e = exp_q.pop_front();
               if (c !== e.cyc || fb_addr !== 17'(e.addr) || fb_data !== 4'(e.data)) begin
                  errors++;
                  $display("FAIL %s write: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                           name, c, fb_addr, fb_data, e.cyc, e.addr, e.data);
               end
            end
         end
         if (c == abort_c) begin
            rst = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || fb_we !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s abort_edge: got busy=%b fb_we=%b done=%b, required 0 0 0", name, busy, fb_we, done);
            end
            rst = 1'b0;
            quiet = 1;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               if (busy || done || fb_we) quiet = 0;
            end
            checks++;
            if (!quiet) begin
               errors++;
               $display("FAIL %s after_abort: got activity after reset, required idle outputs", name);
            end
            break;
         end
         if (c < 4099) @(posedge clk);
      end
      checks++;
      if (obs_writes !== exp_writes) begin
         errors++;
         $display("FAIL %s write_count: got %0d, required %0d", name, obs_writes, exp_writes);
      end
      if (abort_c < 0) begin
         checks++;
         if (done_cnt !== 1 || obs_done_c !== 4098) begin
            errors++;
            $display("FAIL %s done: got count=%0d cyc=%0d, required count=1 cyc=4098", name, done_cnt, obs_done_c);
         end
         checks++;
         if (busy_cnt !== 4098 || busy_end !== 0) begin
            errors++;
            $display("FAIL %s busy: got cycles=%0d busy_c4099=%0d, required 4098 and 0", name, busy_cnt, busy_end);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pos_x = '0; pos_y = '0;
`ifdef BLIT_FLIP_X_EN
      flip_x = 1'b0;
`endif
      fill_rom(4'h9);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, fb_we} !== 3'b000 || rom_address !== 12'd0 || fb_addr !== 17'd0 || fb_data !== 4'h0) begin
         errors++;
         $display("FAIL reset_values: got busy=%b done=%b we=%b rom=%0d fb_addr=%0d data=%0h, required all 0",
                  busy, done, fb_we, rom_address, fb_addr, fb_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_opaque();
      fill_rom(4'h5);
      run_blit("opaque", 10'd10, 10'd20, 1'b0, 0, -1, -1);
      checks++;
      if (obs_writes !== 4096 || first_addr !== 20 * 320 + 10 || first_cyc !== 2 ||
          last_addr !== 83 * 320 + 73 || last_cyc !== 4097) begin
         errors++;
         $display("FAIL opaque_ends: got n=%0d first=%0d@c%0d last=%0d@c%0d, required 4096 6410@c2 26633@c4097",
                  obs_writes, first_addr, first_cyc, last_addr, last_cyc);
      end
   endtask

   task automatic test_transparency();
      fill_rom(4'h3);
      rom_mem[0] = 4'h0;
      run_blit("transparency", 10'd0, 10'd0, 1'b0, 0, -1, -1);
      checks++;
      if (hit_addr0 || obs_writes !== 4095) begin
         errors++;
         $display("FAIL transparency_skip: got addr0_written=%0d n=%0d, required 0 and 4095", hit_addr0, obs_writes);
      end
   endtask

   task automatic test_clipping();
      fill_rom(4'hA);
      run_blit("clipping", 10'd300, 10'd200, 1'b0, 0, -1, -1);
      checks++;
      if (obs_writes !== 800) begin
         errors++;
         $display("FAIL clipping_count: got %0d, required 800", obs_writes);
      end
      run_blit("clip_far", 10'd1020, 10'd1023, 1'b0, 0, -1, -1);
      checks++;
      if (obs_writes !== 0) begin
         errors++;
         $display("FAIL clip_far_count: got %0d, required 0", obs_writes);
      end
   endtask

   task automatic test_start_mid_blit();
      fill_rom(4'h6);
      run_blit("start_mid", 10'd40, 10'd30, 1'b0, 0, 100, -1);
   endtask

   task automatic test_reset_mid_blit();
      fill_rom(4'hC);
      run_blit("reset_mid", 10'd5, 10'd7, 1'b0, 0, -1, 2000);
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d done pulses, required 0", done_cnt);
      end
      run_blit("after_reset", 10'd64, 10'd64, 1'b0, 0, -1, -1);
   endtask

   task automatic test_back_to_back();
      fill_rom(4'h2);
      run_blit("b2b_first", 10'd100, 10'd50, 1'b0, 1, -1, -1);
      run_blit("b2b_second", 10'd200, 10'd150, 1'b0, 0, -1, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 4096; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         run_blit("random", 10'($urandom_range(0, 330)), 10'($urandom_range(0, 250)), 1'b0, 0, -1, -1);
      end
   endtask

`ifdef BLIT_FLIP_X_EN
   task automatic test_flip_x();
      fill_rom(4'h0);
      rom_mem[0] = 4'h7;
      run_blit("flip_x", 10'd0, 10'd0, 1'b1, 0, -1, -1);
      checks++;
      if (obs_writes !== 1 || last_addr !== 63) begin
         errors++;
         $display("FAIL flip_x_single: got n=%0d addr=%0d, required 1 write at 63", obs_writes, last_addr);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_opaque();
      test_transparency();
      test_clipping();
      test_start_mid_blit();
      test_reset_mid_blit();
      test_back_to_back();
      test_random();
`ifdef BLIT_FLIP_X_EN
      test_flip_x();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
